// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, sizes and helpers for the 7-seg page scheduler
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SHOW = 2'd2
    } seg_state_t;

    localparam int DIGITS  = 8;
    localparam int NIB_W   = 4;
    localparam int WORD_W  = DIGITS * NIB_W;
    localparam int MAX_REQ = 8;

    // One-hot vector with bit idx set
    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Index of the set bit of a one-hot vector (0 when none is set)
    function automatic logic [2:0] index_of(input logic [MAX_REQ-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_rr_arbiter.sv
// rtl/seg_rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module seg_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    // First requester found scanning rr_ptr, rr_ptr+1, ... wrapping at NREQ
    always_comb begin
        int j;
        winner = '0;
        valid  = 1'b0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                winner = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/seg_page_scheduler.sv
// rtl/seg_page_scheduler.sv - round-robin sharing of the 8-digit 7-seg display
module seg_page_scheduler
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 150000,
    parameter int DWELL_FRAMES = 256,
    parameter int NREQ         = 4,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   data,
    input  logic                 hold,
    output logic [NREQ-1:0]      grant,
    output logic [NIB_W-1:0]     dig,
    output logic [2:0]           pos,
    output logic                 point,
    output logic                 off,
    output logic                 frame_done
);

    localparam int PS_W  = $clog2(SCAN_DIV);
    localparam int DW_W  = $clog2(DWELL_FRAMES + 1);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL_FRAMES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);
    localparam logic [2:0]       POS_LAST = 3'(DIGITS - 1);

    seg_state_t       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [2:0]       pos_q, pos_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             wrap;
    logic             owner_drop;
    logic             expire;
    logic [IDX_W-1:0] winner;
    logic             win_valid;
    logic [WORD_W-1:0] word;
    logic             show;

    seg_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (winner),
        .valid  (win_valid)
    );

    // State register and counters; reset returns everything to the blank idle display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            presc_q      <= '0;
            pos_q        <= '0;
            dwell_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            presc_q      <= presc_d;
            pos_q        <= pos_d;
            dwell_q      <= dwell_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state: arbitration, scan prescaler, digit position and dwell accounting
    always_comb begin
        tick       = (presc_q == PS_LAST);
        wrap       = (state_q == SHOW) && tick && (pos_q == POS_LAST);
        owner_drop = (state_q == SHOW) && ((grant_q & req) == '0);
        // With hold set the dwell count parks at its last value, so release
        // re-arbitrates at the very next frame wrap.
        expire     = wrap && (dwell_q == DW_LAST) && !hold;

        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        presc_d      = tick ? '0 : presc_q + 1'b1;
        pos_d        = '0;
        dwell_d      = '0;
        frame_done_d = wrap;

        case (state_q)
            IDLE: begin
                if (|req) state_d = ARB;
            end
            ARB: begin
                presc_d = '0;
                if (win_valid) begin
                    state_d  = SHOW;
                    grant_d  = NREQ'(onehot(3'(winner)));
                    rr_ptr_d = (winner == IDX_LAST) ? '0 : winner + 1'b1;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            SHOW: begin
                pos_d   = tick ? pos_q + 3'd1 : pos_q;
                dwell_d = dwell_q;
                if (wrap && (dwell_q != DW_LAST)) dwell_d = dwell_q + 1'b1;
                if (owner_drop || expire) begin
                    state_d = ARB;
                    pos_d   = '0;
                    dwell_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Display outputs: live word of the owner, current nibble, page dot and leading-zero blanking
    always_comb begin
        word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) word = word | data[32*i +: 32];
        end
        show  = (state_q == SHOW);
        dig   = show ? word[{pos_q, 2'b00} +: NIB_W] : '0;
        point = show && (pos_q == index_of(MAX_REQ'(grant_q)));
        off   = !show ||
                ((LZ_SUPPRESS != 0) && (pos_q != 3'd0) && ((word >> {pos_q, 2'b00}) == '0));
    end

    assign grant      = grant_q;
    assign pos        = pos_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_page_scheduler.sv
// tb/tb_seg_page_scheduler.sv - directed self-checking bench for seg_page_scheduler
module tb_seg_page_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] data = '0;
    logic         hold = 1'b0;
    logic [3:0]   grant;
    logic [3:0]   dig;
    logic [2:0]   pos;
    logic         point;
    logic         off;
    logic         frame_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg_page_scheduler #(
        .SCAN_DIV     (4),
        .DWELL_FRAMES (2),
        .NREQ         (4),
        .LZ_SUPPRESS  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data       (data),
        .hold       (hold),
        .grant      (grant),
        .dig        (dig),
        .pos        (pos),
        .point      (point),
        .off        (off),
        .frame_done (frame_done)
    );

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reset, then raise req; returns in the first SHOW cycle (scan slot 0)
    task automatic start(input logic [3:0] r, input logic h);
        rst_n = 1'b0; req = '0; hold = h;
        go(2);
        rst_n = 1'b1;
        go(1);
        req = r;
        go(2);
    endtask

    task automatic test_reset();
        int pulses;
        #1;
        tests++;
        if ({grant, pos, dig, point, off, frame_done} !== {4'b0, 3'd0, 4'h0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: got g=%b p=%0d d=%h pt=%b off=%b fd=%b want g=0000 p=0 d=0 pt=0 off=1 fd=0",
                     grant, pos, dig, point, off, frame_done);
        end
        data = '0; data[31:0] = 32'hFFFF_FFFF;
        start(4'b0001, 1'b0);
        go(12);
        tests++;
        if (pos !== 3'd3 || grant !== 4'b0001) begin
            fails++; $display("FAIL reset_pre_show: got pos=%0d g=%b want pos=3 g=0001", pos, grant);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({grant, off, pos} !== {4'b0000, 1'b1, 3'd0}) begin
            fails++; $display("FAIL reset_async: got g=%b off=%b pos=%0d want g=0000 off=1 pos=0", grant, off, pos);
        end
        go(1);
        rst_n = 1'b1; req = '0;
        pulses = 0;
        repeat (60) begin
            @(posedge clk); #2;
            if (frame_done) pulses++;
        end
        tests++;
        if (pulses !== 0 || grant !== 4'b0000 || off !== 1'b1) begin
            fails++; $display("FAIL reset_idle: got pulses=%0d g=%b off=%b want 0 0000 1", pulses, grant, off);
        end
    endtask

    task automatic test_single();
        logic [3:0] ed [8];
        logic       eo [8];
        logic       ept;
        ed = '{4'hF, 4'h3, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        eo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        data = '0; data[31:0] = 32'h0000_0A3F;
        start(4'b0001, 1'b0);
        tests++;
        if (grant !== 4'b0001) begin
            fails++; $display("FAIL single_grant: got %b want 0001", grant);
        end
        for (int p = 0; p < 8; p++) begin
            ept = (p == 0);
            tests++;
            if (pos !== 3'(p) || dig !== ed[p] || off !== eo[p] || point !== ept) begin
                fails++;
                $display("FAIL single_digit%0d: got pos=%0d dig=%h off=%b pt=%b want pos=%0d dig=%h off=%b pt=%b",
                         p, pos, dig, off, point, p, ed[p], eo[p], ept);
            end
            go(4);
        end
        tests++;
        if (frame_done !== 1'b1 || pos !== 3'd0 || grant !== 4'b0001) begin
            fails++; $display("FAIL single_wrap: got fd=%b pos=%0d g=%b want 1 0 0001", frame_done, pos, grant);
        end
        go(1);
        tests++;
        if (frame_done !== 1'b0) begin
            fails++; $display("FAIL single_fd_pulse: got %b want 0", frame_done);
        end
        go(31);
        tests++;
        if (off !== 1'b1 || pos !== 3'd0) begin
            fails++; $display("FAIL single_arb: got off=%b pos=%0d want off=1 pos=0", off, pos);
        end
        go(1);
        tests++;
        if (grant !== 4'b0001 || off !== 1'b0) begin
            fails++; $display("FAIL single_regrant: got g=%b off=%b want 0001 0", grant, off);
        end
    endtask

    task automatic test_rotation();
        data = '0; data[31:0] = 32'h1111_1111; data[95:64] = 32'h2222_2222;
        start(4'b0101, 1'b0);
        go(32);
        tests++;
        if (grant !== 4'b0001 || frame_done !== 1'b1) begin
            fails++; $display("FAIL rot_frame1: got g=%b fd=%b want 0001 1", grant, frame_done);
        end
        go(31);
        tests++;
        if (grant !== 4'b0001 || off !== 1'b0) begin
            fails++; $display("FAIL rot_last_slot: got g=%b off=%b want 0001 0", grant, off);
        end
        go(1);
        tests++;
        if (off !== 1'b1) begin
            fails++; $display("FAIL rot_arb1: got off=%b want 1", off);
        end
        go(1);
        tests++;
        if (grant !== 4'b0100 || dig !== 4'h2 || point !== 1'b0) begin
            fails++; $display("FAIL rot_second: got g=%b dig=%h pt=%b want 0100 2 0", grant, dig, point);
        end
        go(8);
        tests++;
        if (pos !== 3'd2 || point !== 1'b1) begin
            fails++; $display("FAIL rot_point: got pos=%0d pt=%b want 2 1", pos, point);
        end
        go(56);
        tests++;
        if (off !== 1'b1) begin
            fails++; $display("FAIL rot_arb2: got off=%b want 1", off);
        end
        go(1);
        tests++;
        if (grant !== 4'b0001) begin
            fails++; $display("FAIL rot_back: got g=%b want 0001", grant);
        end
    endtask

    task automatic test_hold();
        data = '0; data[31:0] = 32'h0000_0001; data[63:32] = 32'h0000_0002;
        start(4'b0011, 1'b1);
        go(321);
        tests++;
        if (grant !== 4'b0001) begin
            fails++; $display("FAIL hold_10_frames: got g=%b want 0001", grant);
        end
        hold = 1'b0;
        go(30);
        tests++;
        if (grant !== 4'b0001 || pos !== 3'd7) begin
            fails++; $display("FAIL hold_release_wait: got g=%b pos=%0d want 0001 7", grant, pos);
        end
        go(1);
        tests++;
        if (off !== 1'b1 || pos !== 3'd0) begin
            fails++; $display("FAIL hold_arb: got off=%b pos=%0d want 1 0", off, pos);
        end
        go(1);
        tests++;
        if (grant !== 4'b0010) begin
            fails++; $display("FAIL hold_switch: got g=%b want 0010", grant);
        end
    endtask

    task automatic test_drop();
        data = '0; data[31:0] = 32'h1234_5678; data[95:64] = 32'h9ABC_DEF0;
        start(4'b0101, 1'b0);
        go(12);
        tests++;
        if (pos !== 3'd3 || dig !== 4'h5) begin
            fails++; $display("FAIL drop_pre: got pos=%0d dig=%h want 3 5", pos, dig);
        end
        req = 4'b0100;
        go(1);
        tests++;
        if (off !== 1'b1 || pos !== 3'd0) begin
            fails++; $display("FAIL drop_arb: got off=%b pos=%0d want 1 0", off, pos);
        end
        go(1);
        tests++;
        if ({grant, pos, dig, off, point} !== {4'b0100, 3'd0, 4'h0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL drop_next: got g=%b pos=%0d dig=%h off=%b pt=%b want 0100 0 0 0 0",
                              grant, pos, dig, off, point);
        end
        go(8);
        tests++;
        if (pos !== 3'd2 || dig !== 4'hE || point !== 1'b1) begin
            fails++; $display("FAIL drop_pos2: got pos=%0d dig=%h pt=%b want 2 e 1", pos, dig, point);
        end
        req = 4'b0000;
        go(2);
        tests++;
        if (grant !== 4'b0000 || off !== 1'b1) begin
            fails++; $display("FAIL drop_idle: got g=%b off=%b want 0000 1", grant, off);
        end
        go(5);
        tests++;
        if (grant !== 4'b0000 || off !== 1'b1 || pos !== 3'd0) begin
            fails++; $display("FAIL drop_stay_idle: got g=%b off=%b pos=%0d want 0000 1 0", grant, off, pos);
        end
    endtask

    task automatic test_data_patterns();
        logic eoff;
        data = '0;
        start(4'b0001, 1'b0);
        for (int p = 0; p < 8; p++) begin
            eoff = (p != 0);
            tests++;
            if (pos !== 3'(p) || dig !== 4'h0 || off !== eoff) begin
                fails++; $display("FAIL zero_digit%0d: got pos=%0d dig=%h off=%b want %0d 0 %b",
                                  p, pos, dig, off, p, eoff);
            end
            if (p != 7) go(4);
        end
        data[31:0] = 32'hFFFF_FFFF;
        #1;
        tests++;
        if (off !== 1'b0 || dig !== 4'hF) begin
            fails++; $display("FAIL live_update: got off=%b dig=%h want 0 f", off, dig);
        end
        go(4);
        for (int p = 0; p < 8; p++) begin
            tests++;
            if (pos !== 3'(p) || dig !== 4'hF || off !== 1'b0) begin
                fails++; $display("FAIL ones_digit%0d: got pos=%0d dig=%h off=%b want %0d f 0",
                                  p, pos, dig, off, p);
            end
            go(4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_hold();
        test_drop();
        test_data_patterns();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
